arrow_lane_scheduler: RTL and testbench
=======================================

Name: arrow_lane_scheduler

Overview:
Sequences the four falling-arrow lanes of the rhythm game.
- Decides when and in which lane the next arrow spawns, and at what speed.
- Judges hand-gesture presses against each lane's arrow position.
- Keeps score, combo and miss counts, and runs the IDLE/PLAY/GAMEOVER flow.
- Sits between the gesture/button front-end and the four arrow renderers. It drives their restart inputs and reads back their vertical centres.

Parameters:
- NLANES, 4: lane count (fixed at 4; lane index is 2 bits).
- SPAWN_FRAMES, 40: frames between spawn attempts.
- MIN_SPAWN_FRAMES, 12: floor for spawn interval (ramp feature only).
- HIT_LO, 400: inclusive lower y of hit window.
- HIT_HI, 440: inclusive upper y of hit window.
- MISS_Y, 460: y at or beyond which an active arrow is missed.
- MAX_MISS, 8: misses that end the game.
- LFSR_SEED, 8'hA5: LFSR reset value (must be nonzero).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- frame_tick  in  1  one-cycle pulse per video frame (animate qualifier).
- start  in  1  level; starts or restarts a game.
- btn  in  4  debounced lane gestures, level, bit i = lane i.
- lane_y  in  40  packed lane centres; lane i occupies bits [10i+9:10i].
- spawn  out  4  one-cycle restart pulse per lane (to lane restart input).
- lane_speed  out  8  2-bit speed code per lane, lane i at [2i+1:2i].
- visible  out  4  lane arrow shown (active mask).
- score  out  16  hits, saturating.
- combo  out  8  consecutive hits, saturating.
- misses  out  4  miss count.
- state  out  2  0=IDLE, 1=PLAY, 2=GAMEOVER.

Behaviour:
- Reset values: state=IDLE; spawn, visible, score, combo, misses and lane_speed all 0; interval counter=SPAWN_FRAMES; LFSR=LFSR_SEED; btn history=0.
- LFSR: 8-bit Fibonacci, taps 8,6,5,4; shifts every clk in all states.
- IDLE and GAMEOVER: start=1 → PLAY next cycle. On entry to PLAY, clear score, combo, misses and visible, and reload the interval counter.
- PLAY, interval counter:
  - Decrements on each frame_tick.
  - When a frame_tick arrives with counter==1: reload it, pick lane L=lfsr[1:0] and speed lfsr[3:2].
  - If visible[L]==0: the next cycle asserts spawn[L] for exactly one cycle, sets visible[L], and registers lane_speed[L].
  - If visible[L]==1: the attempt is dropped; there is no retry until the next interval.
- Press detection: registered rising edge of btn (btn & ~btn_q); judgement happens one cycle after the edge.
- Hit: edge on lane i, visible[i]=1, and HIT_LO ≤ lane_y[i] ≤ HIT_HI.
  - score+1, combo+1, clear visible[i], pulse spawn[i].
  - The spawn pulse parks the renderer back at its start position, hidden.
- Wrong press: edge on a lane that is not visible, or is outside the window → combo cleared; score unchanged.
- Miss: visible[i]=1 and lane_y[i] ≥ MISS_Y → misses+1, combo cleared, visible[i] cleared. Checked only on frame_tick cycles, so each arrow is counted once.
- Simultaneous events:
  - Multiple lanes in one cycle: each lane is judged independently. score and misses add the popcount of events; combo clears if any miss or wrong press occurred, otherwise it adds the hit count.
  - Hit and miss on the same lane in the same cycle: hit wins.
  - Spawn and judgement of the same lane in the same cycle: judgement wins and the spawn is dropped.
- Game over: when misses reaches MAX_MISS → GAMEOVER next cycle. visible is cleared, spawn is held 0, and score/combo are held.
- Saturation: score saturates at 16'hFFFF, combo at 8'hFF; misses stops at MAX_MISS.
- Mid-game reset: rst in any state returns everything to its reset values on the next edge; any spawn pulse in flight is cancelled.
- start while in PLAY is ignored.

Optional Feature:
- With SCHED_DIFFICULTY_RAMP_EN defined: every 16th cumulative hit reduces the reload value by 2, floored at MIN_SPAWN_FRAMES. The reload value restores to SPAWN_FRAMES on entering PLAY.
- Without it: the reload value is always SPAWN_FRAMES and no ramp counter is synthesised.

Decomposition:
- Package hdr_pkg holds:
  - state enum (IDLE, PLAY, GAMEOVER);
  - screen constants (640×480);
  - the shared y limits HIT_LO, HIT_HI, MISS_Y.
- One sub-module, hdr_lfsr8 (seed parameter, free-running 8-bit output).
- Per-lane judgement stays inline in a generate loop.

Test Plan:
- rst, then start=1 for 1 cycle → state=1 next cycle. After 40 frame_ticks, exactly one spawn bit pulses for 1 cycle; that lane's visible=1 and lane_speed matches LFSR bits [3:2].
- Lane 2 visible with lane_y=420, rising edge on btn[2] → two cycles later score=1, combo=1, visible[2]=0, spawn[2] pulsed once.
- Lane 0 visible with lane_y=460 at frame_tick → misses=1, combo=0, visible[0]=0. Holding lane_y=470 on later ticks does not increment misses again.
- btn[1] edge with lane 1 invisible while combo=5 → combo=0, score unchanged. Holding btn[1] high produces no further events.
- Same cycle: lane 0 hit plus lane 3 miss → score+1, misses+1, combo=0. Eight total misses → state=2, visible=0, and spawns stay 0 for 200 frames.
- rst asserted mid-PLAY with score=37 → next cycle state=0, score=0, spawn=0, lfsr=8'hA5. With SCHED_DIFFICULTY_RAMP_EN, 32 hits → spawn interval measures 36 frames.

Source files
------------

// File: rtl/hdr_pkg.sv
// rtl/hdr_pkg.sv - Shared state encoding, screen geometry and lane y limits for the arrow lane scheduler
package hdr_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PLAY     = 2'd1,
        GAMEOVER = 2'd2
    } sched_state_t;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    // Width of one lane_y field: enough to hold any screen coordinate.
    localparam int Y_W = $clog2((SCREEN_W > SCREEN_H) ? SCREEN_W : SCREEN_H);

    localparam int HIT_LO = 400;
    localparam int HIT_HI = 440;
    localparam int MISS_Y = 460;

    function automatic logic [2:0] popcount4(input logic [3:0] v);
        return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
    endfunction

endpackage

// File: rtl/hdr_lfsr8.sv
// rtl/hdr_lfsr8.sv - Free-running 8-bit Fibonacci LFSR (taps 8,6,5,4) with a reset seed
module hdr_lfsr8 #(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    output logic [7:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= SEED;
        end else begin
            q <= {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
        end
    end

endmodule

// File: rtl/arrow_lane_scheduler.sv
// rtl/arrow_lane_scheduler.sv - Four-lane arrow spawn, press judgement, scoring and game flow
// Define SCHED_DIFFICULTY_RAMP_EN to shorten the spawn interval by 2 frames every 16 hits.
module arrow_lane_scheduler #(
    parameter int         NLANES           = 4,
    parameter int         SPAWN_FRAMES     = 40,
    parameter int         MIN_SPAWN_FRAMES = 12,
    parameter int         HIT_LO           = hdr_pkg::HIT_LO,
    parameter int         HIT_HI           = hdr_pkg::HIT_HI,
    parameter int         MISS_Y           = hdr_pkg::MISS_Y,
    parameter int         MAX_MISS         = 8,
    parameter logic [7:0] LFSR_SEED        = 8'hA5
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          frame_tick,
    input  logic                          start,
    input  logic [NLANES-1:0]             btn,
    input  logic [NLANES*hdr_pkg::Y_W-1:0] lane_y,
    output logic [NLANES-1:0]             spawn,
    output logic [2*NLANES-1:0]           lane_speed,
    output logic [NLANES-1:0]             visible,
    output logic [15:0]                   score,
    output logic [7:0]                    combo,
    output logic [3:0]                    misses,
    output logic [1:0]                    state
);
    import hdr_pkg::*;

    sched_state_t      cur, nxt;
    logic [7:0]        lfsr;
    logic [7:0]        cnt;
    logic [7:0]        reload;
    logic [NLANES-1:0] btn_q, press, hit, wrong, miss, spawn_set;
    logic [2:0]        hit_n, miss_n;
    logic [16:0]       score_sum;
    logic [8:0]        combo_sum;
    logic [4:0]        miss_sum;
    logic              spawn_try;
    logic              unused_lfsr;

    hdr_lfsr8 #(.SEED(LFSR_SEED)) u_lfsr (.clk(clk), .rst(rst), .q(lfsr));
    assign unused_lfsr = ^lfsr[7:4];

    // Hit takes priority over miss on the same lane, so miss is masked by hit.
    for (genvar i = 0; i < NLANES; i++) begin : g_lane
        logic [Y_W-1:0] y;
        logic           in_win;
        assign y        = lane_y[i*Y_W +: Y_W];
        assign in_win   = (y >= Y_W'(HIT_LO)) && (y <= Y_W'(HIT_HI));
        assign hit[i]   = press[i] & visible[i] & in_win;
        assign wrong[i] = press[i] & ~(visible[i] & in_win);
        assign miss[i]  = frame_tick & visible[i] & (y >= Y_W'(MISS_Y)) & ~hit[i];
    end

    assign hit_n     = popcount4(hit);
    assign miss_n    = popcount4(miss);
    assign score_sum = {1'b0, score} + 17'(hit_n);
    assign combo_sum = {1'b0, combo} + 9'(hit_n);
    assign miss_sum  = {1'b0, misses} + 5'(miss_n);
    assign spawn_try = (cur == PLAY) && frame_tick && (cnt == 8'd1);
    assign state     = cur;

    // A press on the chosen lane in the same cycle is judged and the spawn is dropped.
    always_comb begin
        spawn_set = '0;
        if (spawn_try && !visible[lfsr[1:0]] && !press[lfsr[1:0]]) begin
            spawn_set[lfsr[1:0]] = 1'b1;
        end
    end

    always_comb begin
        nxt = cur;
        case (cur)
            IDLE, GAMEOVER: if (start) nxt = PLAY;
            PLAY:           if (misses >= 4'(MAX_MISS)) nxt = GAMEOVER;
            default:        nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur <= IDLE;
        end else begin
            cur <= nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            btn_q      <= '0;
            press      <= '0;
            spawn      <= '0;
            visible    <= '0;
            lane_speed <= '0;
            score      <= '0;
            combo      <= '0;
            misses     <= '0;
            cnt        <= 8'(SPAWN_FRAMES);
        end else begin
            btn_q <= btn;
            press <= btn & ~btn_q;
            spawn <= '0;
            if (cur != PLAY) begin
                visible <= '0;
                if (nxt == PLAY) begin
                    score  <= '0;
                    combo  <= '0;
                    misses <= '0;
                    cnt    <= 8'(SPAWN_FRAMES);
                end
            end else if (nxt != PLAY) begin
                visible <= '0;
            end else begin
                if (frame_tick) begin
                    cnt <= (cnt == 8'd1) ? reload : cnt - 8'd1;
                end
                visible <= (visible & ~hit & ~miss) | spawn_set;
                spawn   <= hit | spawn_set;
                if (|spawn_set) begin
                    lane_speed[{lfsr[1:0], 1'b0} +: 2] <= lfsr[3:2];
                end
                score  <= score_sum[16] ? 16'hFFFF : score_sum[15:0];
                combo  <= (|miss || |wrong) ? 8'h00 : (combo_sum[8] ? 8'hFF : combo_sum[7:0]);
                misses <= (miss_sum >= 5'(MAX_MISS)) ? 4'(MAX_MISS) : miss_sum[3:0];
            end
        end
    end

`ifdef SCHED_DIFFICULTY_RAMP_EN
    logic [3:0] ramp_cnt;
    logic [4:0] ramp_sum;

    assign ramp_sum = {1'b0, ramp_cnt} + 5'(hit_n);

    // Carry out of the 4-bit hit counter marks each 16th hit.
    always_ff @(posedge clk) begin
        if (rst || (cur != PLAY && nxt == PLAY)) begin
            ramp_cnt <= '0;
            reload   <= 8'(SPAWN_FRAMES);
        end else if (cur == PLAY && nxt == PLAY) begin
            ramp_cnt <= ramp_sum[3:0];
            if (ramp_sum[4]) begin
                reload <= (reload >= 8'(MIN_SPAWN_FRAMES + 2)) ? reload - 8'd2
                                                               : 8'(MIN_SPAWN_FRAMES);
            end
        end
    end
`else
    logic [7:0] unused_min_spawn;
    assign unused_min_spawn = 8'(MIN_SPAWN_FRAMES);
    assign reload           = 8'(SPAWN_FRAMES);
`endif

endmodule

// File: tb/tb_arrow_lane_scheduler.sv
// tb/tb_arrow_lane_scheduler.sv - Directed vector bench for arrow_lane_scheduler
module tb_arrow_lane_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        frame_tick = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  btn = '0;
    logic [39:0] lane_y = '0;
    logic [3:0]  spawn;
    logic [7:0]  lane_speed;
    logic [3:0]  visible;
    logic [15:0] score;
    logic [7:0]  combo;
    logic [3:0]  misses;
    logic [1:0]  state;

    always #5 clk = ~clk;

    arrow_lane_scheduler dut (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .start(start), .btn(btn),
        .lane_y(lane_y), .spawn(spawn), .lane_speed(lane_speed), .visible(visible),
        .score(score), .combo(combo), .misses(misses), .state(state)
    );

    typedef struct {
        bit         fill;
        logic [3:0] btn;
        int         y0, y1, y2, y3;
        bit         tick;
        int         sc, cb, ms;
        logic [3:0] vis, sp;
        int         st;
    } vec_t;

    vec_t       vecs[18];
    vec_t       hv;
    int         n_checks = 0;
    int         n_fail = 0;
    int         ticks_left = 40;
    int         bad = 0;
    logic [3:0] exp_vis = '0;
    logic [7:0] m_lfsr;

    always @(posedge clk)
        m_lfsr <= rst ? 8'hA5 : {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic do_tick();
        logic [1:0] l;
        logic [1:0] spd;
        logic [3:0] oh;
        bit         attempt;
        int         idx;
        frame_tick = 1'b1;
        attempt = (ticks_left == 1);
        l = m_lfsr[1:0];
        spd = m_lfsr[3:2];
        idx = 2 * int'(l);
        step();
        frame_tick = 1'b0;
        if (attempt) begin
            ticks_left = 40;
            oh = exp_vis[l] ? 4'b0000 : 4'(4'b0001 << l);
            check("spawn_pulse", 32'(spawn), 32'(oh));
            exp_vis = exp_vis | oh;
            check("spawn_visible", 32'(visible), 32'(exp_vis));
            if (oh != 4'b0000) check("lane_speed", 32'(lane_speed[idx +: 2]), 32'(spd));
        end else begin
            ticks_left--;
        end
        step();
        if (attempt) check("spawn_width", 32'(spawn), 32'h0);
    endtask

    task automatic fill();
        int n;
        lane_y = '0;
        btn = '0;
        n = 0;
        while (exp_vis != 4'hF && n < 4000) begin
            do_tick();
            n++;
        end
        check("fill_bound", 32'(n < 4000), 32'h1);
        check("fill_visible", 32'(visible), 32'hF);
    endtask

    task automatic apply(input vec_t v, input int idx);
        btn = v.btn;
        lane_y = {10'(v.y3), 10'(v.y2), 10'(v.y1), 10'(v.y0)};
        step();
        frame_tick = v.tick;
        if (v.tick) ticks_left--;
        step();
        frame_tick = 1'b0;
        check($sformatf("vec%0d_score", idx), 32'(score), 32'(v.sc));
        check($sformatf("vec%0d_combo", idx), 32'(combo), 32'(v.cb));
        check($sformatf("vec%0d_misses", idx), 32'(misses), 32'(v.ms));
        check($sformatf("vec%0d_visible", idx), 32'(visible), 32'(v.vis));
        check($sformatf("vec%0d_spawn", idx), 32'(spawn), 32'(v.sp));
        check($sformatf("vec%0d_state", idx), 32'(state), 32'(v.st));
        exp_vis = v.vis;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        //          fill btn      y0   y1   y2   y3   tk  sc cb ms vis      spawn    st
        vecs[0]  = '{1, 4'b0100,   0,   0, 420,   0, 0,  1, 1, 0, 4'b1011, 4'b0100, 1};
        vecs[1]  = '{0, 4'b0100,   0,   0, 420,   0, 0,  1, 1, 0, 4'b1011, 4'b0000, 1};
        vecs[2]  = '{0, 4'b0000,   0,   0,   0,   0, 0,  1, 1, 0, 4'b1011, 4'b0000, 1};
        vecs[3]  = '{0, 4'b0001, 400,   0,   0,   0, 0,  2, 2, 0, 4'b1010, 4'b0001, 1};
        vecs[4]  = '{0, 4'b0000,   0,   0,   0,   0, 0,  2, 2, 0, 4'b1010, 4'b0000, 1};
        vecs[5]  = '{0, 4'b0010,   0, 440,   0,   0, 0,  3, 3, 0, 4'b1000, 4'b0010, 1};
        vecs[6]  = '{0, 4'b0000,   0,   0,   0,   0, 0,  3, 3, 0, 4'b1000, 4'b0000, 1};
        vecs[7]  = '{0, 4'b0100,   0,   0, 420,   0, 0,  3, 0, 0, 4'b1000, 4'b0000, 1};
        vecs[8]  = '{0, 4'b0000,   0,   0,   0, 459, 1,  3, 0, 0, 4'b1000, 4'b0000, 1};
        vecs[9]  = '{0, 4'b0000,   0,   0,   0, 460, 1,  3, 0, 1, 4'b0000, 4'b0000, 1};
        vecs[10] = '{0, 4'b0000,   0,   0,   0, 470, 1,  3, 0, 1, 4'b0000, 4'b0000, 1};
        vecs[11] = '{1, 4'b0011, 410, 430,   0,   0, 0,  5, 2, 1, 4'b1100, 4'b0011, 1};
        vecs[12] = '{0, 4'b0000,   0,   0,   0,   0, 0,  5, 2, 1, 4'b1100, 4'b0000, 1};
        vecs[13] = '{0, 4'b0100,   0,   0, 441,   0, 0,  5, 0, 1, 4'b1100, 4'b0000, 1};
        vecs[14] = '{0, 4'b0000,   0,   0,   0,   0, 0,  5, 0, 1, 4'b1100, 4'b0000, 1};
        vecs[15] = '{0, 4'b0100,   0,   0, 420, 465, 1,  6, 0, 2, 4'b0000, 4'b0100, 1};
        vecs[16] = '{1, 4'b0000, 470, 470, 470, 470, 1,  6, 0, 6, 4'b0000, 4'b0000, 1};
        vecs[17] = '{1, 4'b0000, 470, 470, 470, 470, 1,  6, 0, 8, 4'b0000, 4'b0000, 1};

        step();
        step();
        check("reset_state", 32'(state), 32'h0);
        check("reset_spawn", 32'(spawn), 32'h0);
        check("reset_visible", 32'(visible), 32'h0);
        check("reset_score", 32'(score), 32'h0);
        check("reset_combo", 32'(combo), 32'h0);
        check("reset_misses", 32'(misses), 32'h0);
        check("reset_speed", 32'(lane_speed), 32'h0);
        check("reset_lfsr", 32'(dut.u_lfsr.q), 32'hA5);

        rst = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        check("start_state", 32'(state), 32'h1);
        ticks_left = 40;
        exp_vis = '0;

        for (int i = 0; i < 18; i++) begin
            if (vecs[i].fill) fill();
            apply(vecs[i], i);
        end

        step();
        check("gameover_state", 32'(state), 32'h2);
        check("gameover_visible", 32'(visible), 32'h0);
        for (int f = 0; f < 200; f++) begin
            frame_tick = 1'b1;
            step();
            frame_tick = 1'b0;
            if (spawn !== 4'b0000 || visible !== 4'b0000) bad++;
            step();
            if (spawn !== 4'b0000) bad++;
        end
        check("gameover_quiet", 32'(bad), 32'h0);
        check("gameover_score_held", 32'(score), 32'h6);
        check("gameover_state_held", 32'(state), 32'h2);

        start = 1'b1;
        step();
        start = 1'b0;
        check("restart_state", 32'(state), 32'h1);
        check("restart_score", 32'(score), 32'h0);
        check("restart_misses", 32'(misses), 32'h0);
        ticks_left = 40;
        exp_vis = '0;
        fill();
        hv = '{0, 4'b0001, 420, 0, 0, 0, 0, 1, 1, 0, 4'b1110, 4'b0001, 1};
        apply(hv, 100);
        hv = '{0, 4'b0000, 0, 0, 0, 0, 0, 1, 1, 0, 4'b1110, 4'b0000, 1};
        apply(hv, 101);

        start = 1'b1;
        step();
        start = 1'b0;
        step();
        check("start_in_play_state", 32'(state), 32'h1);
        check("start_in_play_score", 32'(score), 32'h1);

        btn = 4'b0010;
        lane_y = {10'd0, 10'd0, 10'd420, 10'd0};
        step();
        rst = 1'b1;
        step();
        check("midreset_state", 32'(state), 32'h0);
        check("midreset_score", 32'(score), 32'h0);
        check("midreset_spawn", 32'(spawn), 32'h0);
        check("midreset_visible", 32'(visible), 32'h0);
        check("midreset_combo", 32'(combo), 32'h0);
        check("midreset_lfsr", 32'(dut.u_lfsr.q), 32'hA5);
        rst = 1'b0;
        btn = '0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
